// File: rtl/uart_rx_word_loader.sv
// uart_rx_word_loader: boot-time UART receiver that packs 8N1 bytes into
// little-endian words for a memory-init write port. The session ends on a word
// limit or an idle timeout; a partial word is flushed on timeout.
// Optional feature macro: UART_PARITY_EN (8E1 framing with sticky parity_err).
module uart_rx_word_loader #(
    parameter int BPS_CNT    = 868,
    parameter int WORD_BYTES = 4,
    parameter int ADDR_WIDTH = 14,
    parameter int MAX_WORDS  = 16384,
    parameter int IDLE_BITS  = 1000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rx,
    output logic [8*WORD_BYTES-1:0] word_out,
    output logic [ADDR_WIDTH-1:0]   word_addr,
    output logic                    word_valid,
    output logic                    frame_err,
    output logic                    parity_err,
    output logic                    done
);
    localparam int CNT_W  = $clog2(BPS_CNT);
    localparam int LANE_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int IDLE_W = $clog2(IDLE_BITS + 1);
    localparam int IDX_W  = ADDR_WIDTH + 1;
    localparam int WORD_W = 8 * WORD_BYTES;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BPS_CNT - 1);
    localparam logic [CNT_W-1:0]  CNT_HALF  = CNT_W'(BPS_CNT / 2 - 1);
    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(WORD_BYTES - 1);
    localparam logic [IDLE_W-1:0] IDLE_SAT  = IDLE_W'(IDLE_BITS);
    localparam logic [IDX_W-1:0]  IDX_MAX   = IDX_W'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3,
        S_FLUSH  = 3'd4,
        S_DONE   = 3'd5
`ifdef UART_PARITY_EN
        ,S_PARITY = 3'd6
`endif
    } state_t;

`ifdef UART_PARITY_EN
    // Even parity: the parity bit equals the XOR of the eight data bits.
    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction
`endif

    state_t              state_q;
    logic                rx_ff1_q, rx_ff2_q, rx_ff3_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [2:0]          bit_q;
    logic [7:0]          shift_q;
    logic [LANE_W-1:0]   lane_q;
    logic [WORD_W-1:0]   asm_q;
    logic [IDX_W-1:0]    idx_q;
    logic [CNT_W-1:0]    idle_cyc_q;
    logic [IDLE_W-1:0]   idle_bits_q;
    logic                got_byte_q;
    logic [WORD_W-1:0]   word_out_q;
    logic [ADDR_WIDTH-1:0] word_addr_q;
    logic                word_valid_q;
    logic                frame_err_q;
    logic                done_q;
    logic                start_edge_s;
    logic                byte_ok_s;
    logic [WORD_W-1:0]   word_d;
`ifdef UART_PARITY_EN
    logic                par_bad_q;
    logic                parity_err_q;
`endif

    assign start_edge_s = rx_ff3_q & ~rx_ff2_q;
`ifdef UART_PARITY_EN
    assign byte_ok_s    = rx_ff2_q & ~par_bad_q;
    assign parity_err   = parity_err_q;
`else
    assign byte_ok_s    = rx_ff2_q;
    assign parity_err   = 1'b0;
`endif
    assign word_out   = word_out_q;
    assign word_addr  = word_addr_q;
    assign word_valid = word_valid_q;
    assign frame_err  = frame_err_q;
    assign done       = done_q;

    // Merge the byte just received into its lane of the word under assembly.
    always_comb begin
        word_d = asm_q;
        word_d[{lane_q, 3'b000} +: 8] = shift_q;
    end

    // Three-stage synchroniser on the asynchronous rx line, idling high.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_ff1_q <= 1'b1;
            rx_ff2_q <= 1'b1;
            rx_ff3_q <= 1'b1;
        end else begin
            rx_ff1_q <= rx;
            rx_ff2_q <= rx_ff1_q;
            rx_ff3_q <= rx_ff2_q;
        end
    end

    // Receive FSM: framing, byte packing, word strobes and session end.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_q        <= 3'd0;
            shift_q      <= 8'h00;
            lane_q       <= '0;
            asm_q        <= '0;
            idx_q        <= '0;
            idle_cyc_q   <= '0;
            idle_bits_q  <= '0;
            got_byte_q   <= 1'b0;
            word_out_q   <= '0;
            word_addr_q  <= '0;
            word_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            done_q       <= 1'b0;
`ifdef UART_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            // A strobe lasts one cycle; the word index advances as it retires.
            if (word_valid_q) begin
                word_valid_q <= 1'b0;
                idx_q        <= idx_q + IDX_W'(1);
            end
            case (state_q)
                S_IDLE: begin
                    if (word_valid_q && ((idx_q + IDX_W'(1)) == IDX_MAX)) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else if (idle_bits_q == IDLE_SAT) begin
                        // Timeout has priority over a simultaneous start edge.
                        if (lane_q != {LANE_W{1'b0}}) begin
                            state_q <= S_FLUSH;
                        end else begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end else if (start_edge_s) begin
                        state_q     <= S_START;
                        cnt_q       <= '0;
                        idle_cyc_q  <= '0;
                        idle_bits_q <= '0;
                    end else if (got_byte_q) begin
                        if (idle_cyc_q == CNT_LAST) begin
                            idle_cyc_q  <= '0;
                            idle_bits_q <= idle_bits_q + IDLE_W'(1);
                        end else begin
                            idle_cyc_q <= idle_cyc_q + CNT_W'(1);
                        end
                    end
                end
                S_START: begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_q <= '0;
                        bit_q <= 3'd0;
                        // A high mid-start sample is a glitch, not a frame.
                        state_q <= rx_ff2_q ? S_IDLE : S_DATA;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_ff2_q, shift_q[7:1]};
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
`ifdef UART_PARITY_EN
                S_PARITY: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q     <= '0;
                        par_bad_q <= (rx_ff2_q != even_parity(shift_q));
                        state_q   <= S_STOP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                        if (!rx_ff2_q) begin
                            frame_err_q <= 1'b1;
                        end
`ifdef UART_PARITY_EN
                        if (par_bad_q) begin
                            parity_err_q <= 1'b1;
                        end
`endif
                        if (byte_ok_s) begin
                            got_byte_q <= 1'b1;
                            if (lane_q == LANE_LAST) begin
                                word_out_q   <= word_d;
                                word_addr_q  <= idx_q[ADDR_WIDTH-1:0];
                                word_valid_q <= 1'b1;
                                lane_q       <= '0;
                                asm_q        <= '0;
                            end else begin
                                asm_q  <= word_d;
                                lane_q <= lane_q + LANE_W'(1);
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_FLUSH: begin
                    // Unfilled upper lanes are already zero in the assembler.
                    word_out_q   <= asm_q;
                    word_addr_q  <= idx_q[ADDR_WIDTH-1:0];
                    word_valid_q <= 1'b1;
                    lane_q       <= '0;
                    asm_q        <= '0;
                    state_q      <= S_DONE;
                end
                S_DONE: begin
                    done_q <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_word_loader.sv
// Self-checking bench for uart_rx_word_loader: a frame-level reference model
// predicts every word strobe and flag; a compare process checks each strobe.
module tb_uart_rx_word_loader;
    localparam int BPS   = 16;
    localparam int WB    = 4;
    localparam int AW    = 14;
    localparam int MAXW  = 2;
    localparam int IDLEB = 20;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            rx = 1'b1;
    logic [8*WB-1:0] word_out;
    logic [AW-1:0]   word_addr;
    logic            word_valid;
    logic            frame_err;
    logic            parity_err;
    logic            done;

    uart_rx_word_loader #(
        .BPS_CNT(BPS), .WORD_BYTES(WB), .ADDR_WIDTH(AW),
        .MAX_WORDS(MAXW), .IDLE_BITS(IDLEB)
    ) dut (
        .clk(clk), .reset(reset), .rx(rx),
        .word_out(word_out), .word_addr(word_addr), .word_valid(word_valid),
        .frame_err(frame_err), .parity_err(parity_err), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [8*WB-1:0] word;
        logic [AW-1:0]   addr;
        logic            fin;
    } exp_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_strobes = 0;
    logic [8*WB-1:0] last_word = '0;
    exp_t        exp_q[$];
    logic        exp_done_next = 1'b0;

    // Reference model state, at the level of whole frames.
    logic [7:0]  m_bytes[$];
    int          m_idx  = 0;
    logic        m_got  = 1'b0;
    logic        m_done = 1'b0;
    logic        m_ferr = 1'b0;
    logic        m_perr = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_bytes.delete();
        m_idx  = 0;
        m_got  = 1'b0;
        m_done = 1'b0;
        m_ferr = 1'b0;
        m_perr = 1'b0;
    endtask

    task automatic model_push_word(input logic is_flush);
        exp_t e;
        e.word = '0;
        for (int k = 0; k < m_bytes.size(); k++) e.word[8*k +: 8] = m_bytes[k];
        e.addr = AW'(m_idx);
        e.fin  = is_flush || (m_idx + 1 == MAXW);
        exp_q.push_back(e);
        m_idx++;
        m_bytes.delete();
        if (e.fin) m_done = 1'b1;
    endtask

    task automatic model_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
        logic par_ok;
        if (m_done) return;
        par_ok = (par_b == ^d);
        if (!stop_b) m_ferr = 1'b1;
        if (!par_ok) m_perr = 1'b1;
        if (stop_b && par_ok) begin
            m_bytes.push_back(d);
            m_got = 1'b1;
            if (m_bytes.size() == WB) model_push_word(1'b0);
        end
    endtask

    task automatic model_timeout();
        if (m_done || !m_got) return;
        if (m_bytes.size() != 0) model_push_word(1'b1);
        else m_done = 1'b1;
    endtask

    // Compare process: every strobe must match the next predicted word, and
    // done must rise exactly one cycle after the session's final strobe.
    always @(negedge clk) begin
        if (exp_done_next) begin
            check("done_after_final_strobe", done, 1'b1);
            exp_done_next = 1'b0;
        end
        if (word_valid) begin
            n_strobes++;
            last_word = word_out;
            if (exp_q.size() == 0) begin
                check("unexpected_strobe_addr", word_addr, {AW{1'bx}});
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("strobe_word", word_out, e.word);
                check("strobe_addr", word_addr, e.addr);
                check("done_low_during_strobe", done, 1'b0);
                exp_done_next = e.fin;
            end
        end
    end

    task automatic send_bit(input logic v);
        rx = v;
        repeat (BPS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
        model_frame(d, stop_b, par_b);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_PARITY_EN
        send_bit(par_b);
`endif
        send_bit(stop_b);
        if (!stop_b) send_bit(1'b1);
    endtask

    task automatic send_good(input logic [7:0] d);
        send_frame(d, 1'b1, ^d);
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_frame_err"}, frame_err, m_ferr);
        check({tag, "_parity_err"}, parity_err, m_perr);
        check({tag, "_done"}, done, m_done);
    endtask

    task automatic reset_dut();
        check("all_strobes_delivered", exp_q.size(), 0);
        rx = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        check("reset_word_out", word_out, '0);
        check("reset_word_addr", word_addr, '0);
        check("reset_word_valid", word_valid, 1'b0);
        check("reset_frame_err", frame_err, 1'b0);
        check("reset_parity_err", parity_err, 1'b0);
        check("reset_done", done, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (4) @(negedge clk);
    endtask

    task automatic hold_idle_timeout();
        model_timeout();
        rx = 1'b1;
        repeat ((IDLEB + 3) * BPS) @(negedge clk);
    endtask

    initial begin
        int saved;
        logic [7:0] d;
        logic stop_b, par_b;
        repeat (2) @(negedge clk);
        reset_dut();

        // One full word, little-endian.
        send_good(8'h78); send_good(8'h56); send_good(8'h34); send_good(8'h12);
        repeat (4) @(negedge clk);
        check("word0_literal", last_word, 32'h12345678);
        check("word0_done_low", done, 1'b0);
        check_flags("word0");

        // Word limit: eight back-to-back bytes, then a byte after done.
        reset_dut();
        for (int i = 0; i < 8; i++) send_good(8'($urandom_range(0, 255)));
        check_flags("limit");
        check("limit_done_literal", done, 1'b1);
        saved = n_strobes;
        send_good(8'hAA);
        repeat (4) @(negedge clk);
        check("no_strobe_after_done", n_strobes, saved);
        check_flags("after_done");

        // Idle timeout flushes a partial word with zeroed upper lanes.
        reset_dut();
        send_good(8'hEF); send_good(8'hBE);
        hold_idle_timeout();
        check("flush_literal", last_word, 32'h0000BEEF);
        check("flush_done_literal", done, 1'b1);
        check_flags("flush");

        // A short low glitch on an idle line is ignored.
        reset_dut();
        saved = n_strobes;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (3 * BPS) @(negedge clk);
        check("glitch_no_strobe", n_strobes, saved);
        check("glitch_frame_err", frame_err, 1'b0);
        send_good(8'h11); send_good(8'h22); send_good(8'h33); send_good(8'h44);
        repeat (4) @(negedge clk);
        check("after_glitch_word", last_word, 32'h44332211);

        // Framing error drops the byte; following good bytes form word 0.
        reset_dut();
        send_frame(8'h55, 1'b0, ^8'h55);
        check("frame_err_literal", frame_err, 1'b1);
        send_good(8'hA1); send_good(8'hB2); send_good(8'hC3); send_good(8'hD4);
        repeat (4) @(negedge clk);
        check("after_ferr_word", last_word, 32'hD4C3B2A1);
        check_flags("ferr");

        // Reset in the middle of a byte discards the partial word and flags.
        send_good(8'h01); send_good(8'h02);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        model_reset();
        m_bytes.delete();
        reset_dut();
        send_good(8'h9A); send_good(8'hBC); send_good(8'hDE); send_good(8'hF0);
        repeat (4) @(negedge clk);
        check("after_midreset_word", last_word, 32'hF0DEBC9A);
        check_flags("midreset");

`ifdef UART_PARITY_EN
        // Even parity: 0x01 needs parity 1, 0x03 needs parity 0.
        reset_dut();
        send_frame(8'h01, 1'b1, 1'b0);
        check("parity_err_literal", parity_err, 1'b1);
        check("parity_no_frame_err", frame_err, 1'b0);
        send_frame(8'h03, 1'b1, 1'b0);
        send_good(8'h04); send_good(8'h05); send_good(8'h06);
        repeat (4) @(negedge clk);
        check("parity_word", last_word, 32'h06050403);
        send_frame(8'h07, 1'b0, 1'b0);
        check_flags("parity_both");
`endif

        // Randomised sessions against the frame-level model.
        for (int s = 0; s < 6; s++) begin
            reset_dut();
            for (int f = 0; f < int'($urandom_range(1, 11)); f++) begin
                d = 8'($urandom_range(0, 255));
                stop_b = ($urandom_range(0, 7) != 0);
                par_b = ^d;
`ifdef UART_PARITY_EN
                if ($urandom_range(0, 7) == 0) par_b = ~par_b;
`endif
                send_frame(d, stop_b, par_b);
                check_flags("rand_frame");
                rx = 1'b1;
                repeat ($urandom_range(0, 2) * BPS) @(negedge clk);
            end
            if ($urandom_range(0, 1) == 1) hold_idle_timeout();
            repeat (4) @(negedge clk);
            check_flags("rand_session");
        end

        repeat (4) @(negedge clk);
        check("final_strobes_delivered", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
